// File: rtl/modexp_ctrl.sv
// Right-to-left square-and-multiply sequencer for C = M^E mod N.
// Drives the shared table-lookup modulo unit one product reduction at a time.
module modexp_ctrl #(
    parameter int DW = 6,
    parameter int EW = 6,
    parameter int AW = 18
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] msg,
    input  logic [EW-1:0] exp,
    input  logic [DW-1:0] modn,
    output logic [AW-1:0] mod_addr,
    output logic          mod_hold,
    input  logic [DW-1:0] mod_data,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [DW-1:0] result
);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_FAIL  = 4'd1,
        S_RED_I = 4'd2,
        S_RED_W = 4'd3,
        S_MUL_I = 4'd4,
        S_MUL_W = 4'd5,
        S_SQR_I = 4'd6,
        S_SQR_W = 4'd7,
        S_FIN   = 4'd8
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] base_q, base_d;
    logic [DW-1:0] acc_q, acc_d;
    logic [EW-1:0] e_sh_q, e_sh_d;
    logic [DW-1:0] n_m1_q, n_m1_d;
    logic [AW-1:0] mod_addr_q, mod_addr_d;
    logic          mod_hold_q, mod_hold_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [DW-1:0] result_q, result_d;

    logic [EW-1:0]   e_shr_s;
    logic [DW-1:0]   op_a_s, op_b_s;
    logic [2*DW-1:0] prod_s;
    logic            issue_s;

    assign e_shr_s = e_sh_q >> 1;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            acc_q      <= '0;
            e_sh_q     <= '0;
            n_m1_q     <= '0;
            mod_addr_q <= '0;
            mod_hold_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            acc_q      <= acc_d;
            e_sh_q     <= e_sh_d;
            n_m1_q     <= n_m1_d;
            mod_addr_q <= mod_addr_d;
            mod_hold_q <= mod_hold_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            result_q   <= result_d;
        end
    end

    // Next-state logic: one ISSUE/WAIT pair per reduction
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (modn == {DW{1'b0}}) ? S_FAIL : S_RED_I;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FAIL:  state_d = S_IDLE;
            S_RED_I: state_d = S_RED_W;
            S_RED_W: begin
                if (e_sh_q == {EW{1'b0}}) begin
                    state_d = S_FIN;
                end else if (e_sh_q[0]) begin
                    state_d = S_MUL_I;
                end else begin
                    state_d = S_SQR_I;
                end
            end
            S_MUL_I: state_d = S_MUL_W;
            S_MUL_W: state_d = (e_shr_s == {EW{1'b0}}) ? S_FIN : S_SQR_I;
            S_SQR_I: state_d = S_SQR_W;
            S_SQR_W: state_d = e_sh_q[0] ? S_MUL_I : S_SQR_I;
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath updates; done/err/result are loaded on entry to FIN/FAIL so they line up
    always_comb begin
        base_d   = base_q;
        acc_d    = acc_q;
        e_sh_d   = e_sh_q;
        n_m1_d   = n_m1_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    busy_d = 1'b1;
                    e_sh_d = exp;
                    n_m1_d = modn - {{(DW-1){1'b0}}, 1'b1};
                    base_d = {DW{1'b0}};
                    acc_d  = (modn == {{(DW-1){1'b0}}, 1'b1}) ? {DW{1'b0}} : {{(DW-1){1'b0}}, 1'b1};
                    if (modn == {DW{1'b0}}) begin
                        done_d   = 1'b1;
                        err_d    = 1'b1;
                        result_d = {DW{1'b0}};
                    end else begin
                        done_d = 1'b0;
                    end
                end else begin
                    busy_d = busy_q;
                end
            end
            S_FAIL: busy_d = 1'b0;
            S_RED_W: begin
                base_d = mod_data;
                if (e_sh_q == {EW{1'b0}}) begin
                    result_d = acc_q;
                    done_d   = 1'b1;
                end else if (!e_sh_q[0]) begin
                    // Going straight to a square: consume the clear low bit now
                    e_sh_d = e_shr_s;
                end else begin
                    e_sh_d = e_sh_q;
                end
            end
            S_MUL_W: begin
                acc_d  = mod_data;
                e_sh_d = e_shr_s;
                if (e_shr_s == {EW{1'b0}}) begin
                    result_d = mod_data;
                    done_d   = 1'b1;
                end else begin
                    done_d = 1'b0;
                end
            end
            S_SQR_W: begin
                base_d = mod_data;
                if (!e_sh_q[0]) begin
                    e_sh_d = e_shr_s;
                end else begin
                    e_sh_d = e_sh_q;
                end
            end
            S_FIN: begin
                result_d = acc_q;
                busy_d   = 1'b0;
            end
            default: begin
                busy_d = busy_q;
            end
        endcase
    end

    // Operand select for the next ISSUE cycle; address is registered on entry
    always_comb begin
        op_a_s  = {DW{1'b0}};
        op_b_s  = {DW{1'b0}};
        issue_s = 1'b0;
        case (state_d)
            S_RED_I: begin
                op_a_s  = msg;
                op_b_s  = {{(DW-1){1'b0}}, 1'b1};
                issue_s = 1'b1;
            end
            S_MUL_I: begin
                op_a_s  = acc_d;
                op_b_s  = base_d;
                issue_s = 1'b1;
            end
            S_SQR_I: begin
                op_a_s  = base_d;
                op_b_s  = base_d;
                issue_s = 1'b1;
            end
            default: begin
                issue_s = 1'b0;
            end
        endcase
        prod_s     = {{DW{1'b0}}, op_a_s} * {{DW{1'b0}}, op_b_s};
        mod_hold_d = ~issue_s;
        if (issue_s) begin
            mod_addr_d = {n_m1_d, prod_s};
        end else begin
            mod_addr_d = mod_addr_q;
        end
    end

    assign mod_addr = mod_addr_q;
    assign mod_hold = mod_hold_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign result   = result_q;

endmodule
